uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
// - UART transmit serializer inside Uart_Driver; sits directly downstream of the AXI-Lite register slave.
// - Accepts one byte per valid/ready handshake and serializes it on o_uart_tx: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// - Baud divider and frame format come from the slave's settings registers (reg2/reg3 fields) and are latched per frame.
// PARAMETERS
// - P_DIV_WIDTH   24  width of i_div_num (clocks per bit)
// - P_DATA_WIDTH  8   width of i_user_tx_data
// PORTS
// - clock            in   1   system clock, the single clock domain
// - reset            in   1   synchronous, active-high reset
// - i_user_tx_data   in   8   byte to send
// - i_user_tx_valid  in   1   byte valid
// - o_user_tx_ready  out  1   engine can accept a byte
// - i_div_num        in   24  clocks per bit period
// - i_data_bit       in   4   number of data bits, 5..8
// - i_stop_bit       in   2   stop-bit code
// - i_check_bit      in   2   parity code
// - i_uart_cts       in   1   clear-to-send, active low; used only with UART_TX_CTS_EN
// - o_uart_tx        out  1   serial line, idle high
// - o_frame_done     out  1   one-cycle pulse at the end of the last stop bit
// BEHAVIOUR
// - Reset values: o_uart_tx=1, o_user_tx_ready=1, o_frame_done=0, state=IDLE, counters=0.
// - Reset mid-frame: line returns high on the next edge and state goes to IDLE; no partial frame resumes.
// - Handshake: a byte is accepted on a rising edge where valid and ready are both high.
//   - ready is high only in IDLE (and gated by CTS when UART_TX_CTS_EN is defined).
//   - ready drops on the edge that accepts the byte.
//   - data and valid are ignored while ready is low.
// - Latching: on acceptance, data, div, data_bit, stop_bit and check_bit are latched. Input changes mid-frame have no effect.
// - Divider: bit period = div_l clocks. div_l = max(i_div_num, 2), so values 0 and 1 act as 2.
//   - Bit counter counts 0..div_l-1; the state advances when count == div_l-1.
// - Data-bit clamp: i_data_bit < 5 acts as 5; i_data_bit > 8 acts as 8. Unsent high data bits are ignored.
// - Parity code (i_check_bit): 0 = none, 1 = odd, 2 = even, 3 = none.
//   - Parity is the XOR of the sent data bits only (inverted for odd).
// - Stop code (i_stop_bit): 2 = two stop bits; any other value = one stop bit.
// - FSM:
//   - IDLE   -(accept)->        START
//   - START  -(1 period)->      DATA
//   - DATA   -(n bits)->        PARITY if parity is enabled, else STOP
//   - PARITY -(1 period)->      STOP
//   - STOP   -(1 or 2 periods)-> IDLE
// - Line levels per state: START = 0; DATA = shift_reg[0], shifted right each period; PARITY = parity bit; STOP and IDLE = 1.
// - Latency: the start bit appears on o_uart_tx at the edge after acceptance. o_uart_tx is registered with no glitches.
// - Frame end: o_frame_done pulses and ready rises on the same edge STOP ends.
// - Back-to-back: with valid held high, the next byte is accepted in the first IDLE cycle. The minimum idle gap between frames is 1 clock at line level 1.
// - Frame length in clocks = div_l * (1 + n + p + s).
// CONFIGURATION
// - Macro UART_TX_CTS_EN.
// - Defined:
//   - i_uart_cts is synchronized through a 2-flop synchronizer.
//   - In IDLE, ready = ~cts_sync.
//   - CTS deasserting mid-frame does not abort; the current frame completes, and the next frame is held until CTS is low.
//   - Added CTS latency is 2 clocks.
// - Not defined: i_uart_cts is unconnected internally and ready = (state == IDLE).
// TESTING
// - div=4, data_bit=8, check=0, stop=1, send 0xA5:
//   - Line is 0 for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks.
//   - o_frame_done pulses 40 clocks after the start edge.
// - div=3, data_bit=7, check=2 (even), send 0x83:
//   - Data bits sent are 1,1,0,0,0,0,0 (bit 7 dropped); parity bit = 0; frame = 30 clocks.
// - div=2, data_bit=8, check=1 (odd), stop=2, send 0x00:
//   - Parity bit = 1, two stop bits, frame = 24 clocks.
// - Mid-frame change and back-to-back: change i_div_num/i_check_bit mid-frame, and hold valid with bytes 0x11 then 0x22.
//   - The first frame keeps its latched format; exactly 1 idle clock precedes the second start bit; ready is low for the whole frame.
// - Edge cases: div=0, data_bit=2, and reset asserted during DATA.
//   - div=0 gives 2-clock bits; data_bit=2 sends 5 bits; reset gives o_uart_tx=1 and ready=1 on the next edge.
// - With UART_TX_CTS_EN defined: hold CTS=1 and assert valid.
//   - ready stays 0 and the line stays 1.
//   - Drop CTS to 0: ready rises 2 clocks later and the frame starts.
//   - Raise CTS mid-frame: the frame completes.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// rtl/uart_tx_engine_if.sv - byte handshake between the register slave and the UART transmit engine
interface uart_tx_engine_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic [P_DATA_WIDTH-1:0] i_user_tx_data;
    logic                    i_user_tx_valid;
    logic                    o_user_tx_ready;

    modport master (
        output i_user_tx_data,
        output i_user_tx_valid,
        input  o_user_tx_ready
    );

    modport slave (
        input  i_user_tx_data,
        input  i_user_tx_valid,
        output o_user_tx_ready
    );
endinterface

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit serializer: start, 5-8 data bits LSB first, optional parity, 1/2 stop bits
// Optional macro UART_TX_CTS_EN gates new frames on a synchronized active-low clear-to-send.
module uart_tx_engine #(
    parameter int P_DIV_WIDTH  = 24,
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_tx_engine_if.slave        user_tx,
    input  logic [P_DIV_WIDTH-1:0] i_div_num,
    input  logic [3:0]             i_data_bit,
    input  logic [1:0]             i_stop_bit,
    input  logic [1:0]             i_check_bit,
    input  logic                   i_uart_cts,
    output logic                   o_uart_tx,
    output logic                   o_frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [P_DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [P_DIV_WIDTH-1:0]  div_q, div_d;
    logic [2:0]              bit_q, bit_d;
    logic [2:0]              last_bit_q, last_bit_d;
    logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    two_stop_q, two_stop_d;
    logic                    stop_idx_q, stop_idx_d;
    logic                    tx_q, tx_d;
    logic                    rdy_q, rdy_d;
    logic                    done_q, done_d;

    logic                    can_send;
    logic                    accept;
    logic                    period_end;
    logic [3:0]              nbits;
    logic [P_DATA_WIDTH-1:0] mask;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_q, cts_d;

    assign cts_d    = {cts_q[0], i_uart_cts};
    assign can_send = rdy_q & ~cts_q[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            cts_q <= 2'b00;
        end else begin
            cts_q <= cts_d;
        end
    end
`else
    logic unused_cts;

    assign unused_cts = i_uart_cts;
    assign can_send   = rdy_q;
`endif

    assign user_tx.o_user_tx_ready = can_send;
    assign accept       = user_tx.i_user_tx_valid & can_send;
    assign period_end   = (cnt_q == div_q - P_DIV_WIDTH'(1));
    assign o_uart_tx    = tx_q;
    assign o_frame_done = done_q;

    assign nbits = (i_data_bit < 4'd5) ? 4'd5 :
                   (i_data_bit > 4'd8) ? 4'd8 : i_data_bit;

    // Only the bits actually sent take part in the parity.
    always_comb begin
        mask = '0;
        for (int i = 0; i < P_DATA_WIDTH; i++) begin
            mask[i] = (i < int'(nbits));
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = period_end ? '0 : cnt_q + P_DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (accept) begin
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    div_d      = (i_div_num < P_DIV_WIDTH'(2)) ? P_DIV_WIDTH'(2) : i_div_num;
                    last_bit_d = 3'(nbits - 4'd1);
                    shift_d    = user_tx.i_user_tx_data;
                    par_en_d   = (i_check_bit == 2'd1) || (i_check_bit == 2'd2);
                    par_bit_d  = (^(user_tx.i_user_tx_data & mask)) ^ (i_check_bit == 2'd1);
                    two_stop_d = (i_stop_bit == 2'd2);
                    stop_idx_d = 1'b0;
                    bit_d      = 3'd0;
                end
            end
            S_START: begin
                if (period_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (period_end) begin
                    if (bit_q == last_bit_q) begin
                        stop_idx_d = 1'b0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (period_end) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (period_end) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= P_DIV_WIDTH'(2);
            bit_q      <= 3'd0;
            last_bit_q <= 3'd7;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] div_num;
    logic [3:0]  data_bit;
    logic [1:0]  stop_bit;
    logic [1:0]  check_bit;
    logic        uart_cts;
    logic        o_uart_tx;
    logic        o_frame_done;

    uart_tx_engine_if #(.P_DATA_WIDTH(8)) user_tx ();

    uart_tx_engine #(
        .P_DIV_WIDTH (24),
        .P_DATA_WIDTH(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .user_tx     (user_tx.slave),
        .i_div_num   (div_num),
        .i_data_bit  (data_bit),
        .i_stop_bit  (stop_bit),
        .i_check_bit (check_bit),
        .i_uart_cts  (uart_cts),
        .o_uart_tx   (o_uart_tx),
        .o_frame_done(o_frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] exp_v, exp_done, cap_v, cap_done, cap_rdy;
    int           exp_n;
    int           cap_k;

    task automatic clear_capture();
        exp_v    = '0;
        exp_done = '0;
        cap_v    = '0;
        cap_done = '0;
        cap_rdy  = '0;
        exp_n    = 0;
        cap_k    = 0;
    endtask

    // Expected line: each character of s is one bit period, repeated div times.
    task automatic add_bits(input string s, input int div);
        for (int i = 0; i < s.len(); i++) begin
            for (int j = 0; j < div; j++) begin
                exp_v[exp_n] = (s[i] == 8'h31);
                exp_n++;
            end
        end
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            cap_v[cap_k]    = o_uart_tx;
            cap_done[cap_k] = o_frame_done;
            cap_rdy[cap_k]  = user_tx.o_user_tx_ready;
            cap_k++;
            @(negedge clock);
        end
    endtask

    // Returns at the negedge right after the accepting edge, valid still high.
    task automatic start_send(input logic [7:0] data, input logic [23:0] div, input logic [3:0] db,
                              input logic [1:0] sb, input logic [1:0] cb, input string name);
        int t;
        user_tx.i_user_tx_data  = data;
        user_tx.i_user_tx_valid = 1'b1;
        div_num   = div;
        data_bit  = db;
        stop_bit  = sb;
        check_bit = cb;
        t = 0;
        while (user_tx.o_user_tx_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL %s_ready_wait: ready=%b after %0d cycles, required 1", name, user_tx.o_user_tx_ready, t);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_line(input string name);
        n_checks++;
        if (cap_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s_line: got %h required %h", name, cap_v, exp_v);
        end
        n_checks++;
        if (cap_done !== exp_done) begin
            n_fail++;
            $display("FAIL %s_done: got %h required %h", name, cap_done, exp_done);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (o_uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx: got %b required 1", o_uart_tx);
        end
        n_checks++;
        if (user_tx.o_user_tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", user_tx.o_user_tx_ready);
        end
        n_checks++;
        if (o_frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b required 0", o_frame_done);
        end
    endtask

    task automatic test_basic();
        clear_capture();
        add_bits("0101001011", 4);
        add_bits("1", 1);
        exp_done[40] = 1'b1;
        start_send(8'hA5, 24'd4, 4'd8, 2'd1, 2'd0, "basic");
        user_tx.i_user_tx_valid = 1'b0;
        capture(exp_n);
        check_line("basic");
        n_checks++;
        if (cap_rdy[40:0] !== (41'd1 << 40)) begin
            n_fail++;
            $display("FAIL basic_ready: got %h required %h", cap_rdy[40:0], 41'd1 << 40);
        end
    endtask

    task automatic test_even_parity();
        clear_capture();
        add_bits("0110000001", 3);
        add_bits("1", 1);
        exp_done[30] = 1'b1;
        start_send(8'h83, 24'd3, 4'd7, 2'd1, 2'd2, "even");
        user_tx.i_user_tx_valid = 1'b0;
        capture(exp_n);
        check_line("even");
    endtask

    task automatic test_odd_two_stop();
        clear_capture();
        add_bits("000000000111", 2);
        add_bits("1", 1);
        exp_done[24] = 1'b1;
        start_send(8'h00, 24'd2, 4'd8, 2'd2, 2'd1, "odd2stop");
        user_tx.i_user_tx_valid = 1'b0;
        capture(exp_n);
        check_line("odd2stop");
    endtask

    task automatic test_back_to_back();
        clear_capture();
        add_bits("0100010001", 4);
        add_bits("1", 1);
        add_bits("00100010011", 2);
        add_bits("1", 1);
        exp_done[40] = 1'b1;
        exp_done[63] = 1'b1;
        start_send(8'h11, 24'd4, 4'd8, 2'd1, 2'd0, "b2b");
        capture(10);
        user_tx.i_user_tx_data = 8'h22;
        div_num   = 24'd2;
        check_bit = 2'd1;
        capture(32);
        user_tx.i_user_tx_valid = 1'b0;
        capture(exp_n - 42);
        check_line("b2b");
        n_checks++;
        if (cap_rdy[41:0] !== (42'd1 << 40)) begin
            n_fail++;
            $display("FAIL b2b_ready: got %h required %h", cap_rdy[41:0], 42'd1 << 40);
        end
    endtask

    task automatic test_edge_cases();
        clear_capture();
        add_bits("0101111", 2);
        add_bits("1", 1);
        exp_done[14] = 1'b1;
        start_send(8'h1D, 24'd0, 4'd2, 2'd0, 2'd0, "edge");
        user_tx.i_user_tx_valid = 1'b0;
        capture(exp_n);
        check_line("edge");
    endtask

    task automatic test_reset_mid_frame();
        logic line_ok;
        start_send(8'h00, 24'd8, 4'd8, 2'd1, 2'd0, "rstmid");
        user_tx.i_user_tx_valid = 1'b0;
        repeat (20) @(negedge clock);
        n_checks++;
        if (o_uart_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_data_level: got %b required 0", o_uart_tx);
        end
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        reset = 1'b0;
        line_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (o_uart_tx !== 1'b1 || user_tx.o_user_tx_ready !== 1'b1 || o_frame_done !== 1'b0) line_ok = 1'b0;
        end
        n_checks++;
        if (line_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_no_resume: got %b required 1", line_ok);
        end
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        logic held_ok;
        int   t;
        uart_cts = 1'b1;
        repeat (3) @(negedge clock);
        user_tx.i_user_tx_data  = 8'h5A;
        user_tx.i_user_tx_valid = 1'b1;
        div_num   = 24'd2;
        data_bit  = 4'd8;
        stop_bit  = 2'd1;
        check_bit = 2'd0;
        held_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (user_tx.o_user_tx_ready !== 1'b0 || o_uart_tx !== 1'b1) held_ok = 1'b0;
            @(negedge clock);
        end
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL cts_hold: got %b required 1", held_ok);
        end
        uart_cts = 1'b0;
        @(negedge clock);
        n_checks++;
        if (user_tx.o_user_tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cts_ready_1clk: got %b required 0", user_tx.o_user_tx_ready);
        end
        @(negedge clock);
        n_checks++;
        if (user_tx.o_user_tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cts_ready_2clk: got %b required 1", user_tx.o_user_tx_ready);
        end
        clear_capture();
        add_bits("0010110101", 2);
        add_bits("1", 1);
        exp_done[20] = 1'b1;
        @(negedge clock);
        user_tx.i_user_tx_valid = 1'b0;
        capture(6);
        uart_cts = 1'b1;
        capture(exp_n - 6);
        check_line("cts");
        t = 0;
        while (t < 10) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (user_tx.o_user_tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cts_next_held: got %b required 0", user_tx.o_user_tx_ready);
        end
        uart_cts = 1'b0;
        repeat (3) @(negedge clock);
    endtask
`endif

    initial begin
        user_tx.i_user_tx_data  = 8'h00;
        user_tx.i_user_tx_valid = 1'b0;
        div_num   = 24'd4;
        data_bit  = 4'd8;
        stop_bit  = 2'd1;
        check_bit = 2'd0;
        uart_cts  = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_even_parity();
        test_odd_two_stop();
        test_back_to_back();
        test_edge_cases();
        test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
